// File: rtl/xc_malu_pkg.sv
// rtl/xc_malu_pkg.sv - shared types, legal parameter values and helpers for the MALU multiplier
package xc_malu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } malu_state_e;

  localparam int LEGAL_XLEN [4] = '{8, 16, 32, 64};
  localparam int LEGAL_BPC  [3] = '{1, 2, 4};
  localparam int MAX_XLEN       = 64;
  localparam int MAX_PROD       = 2 * MAX_XLEN;

  // Callers zero-extend into the widest product and truncate back to 2*XLEN;
  // the low bits of a wide negation equal the narrow negation.
  function automatic logic [MAX_PROD-1:0] neg2x(input logic [MAX_PROD-1:0] v);
    return (~v) + MAX_PROD'(1);
  endfunction

endpackage

// File: rtl/xc_malu_mul_step.sv
// rtl/xc_malu_mul_step.sv - one combinational multiply step: folds BITS_PER_CYCLE partial products into acc
module xc_malu_mul_step
  import xc_malu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int STEP_W         = $clog2(XLEN / BITS_PER_CYCLE)
) (
  input  logic [2*XLEN-1:0]         acc_i,
  input  logic [XLEN-1:0]           lhs_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  input  logic [STEP_W-1:0]         step_i,
  input  logic                      carryless_i,
  output logic [2*XLEN-1:0]         acc_o
);

  localparam int PW = 2 * XLEN;

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      logic [PW-1:0] pp;
      pp = {{XLEN{1'b0}}, lhs_i} << (int'(step_i) * BITS_PER_CYCLE + i);
      if (bits_i[i]) begin
        acc_o = carryless_i ? (acc_o ^ pp) : (acc_o + pp);
      end
    end
  end

endmodule

// File: rtl/xc_malu_mul_seq.sv
// rtl/xc_malu_mul_seq.sv - constant-time sequential signed/unsigned/carry-less multiplier
module xc_malu_mul_seq
  import xc_malu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic              lhs_sign,
  input  logic              rhs_sign,
  input  logic              carryless,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] result,
  output logic              busy
);

  localparam int N_STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW      = $clog2(N_STEPS);
  localparam int PW      = 2 * XLEN;

  malu_state_e     state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   result_q, result_d;
  logic [XLEN-1:0] lhs_q, lhs_d;
  logic [XLEN-1:0] arg_q, arg_d;
  logic            neg_q, neg_d;
  logic            cl_q, cl_d;
  logic [CW-1:0]   count_q, count_d;

  logic [CW-1:0]   step_idx;
  logic [PW-1:0]   acc_step;
  logic [PW-1:0]   acc_neg;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;

  // Magnitudes are taken up front so the datapath is a plain unsigned/GF(2)
  // shift-add; the sign is re-applied once on the final step.
  assign rs1_neg  = lhs_sign && !carryless && rs1[XLEN-1];
  assign rs2_neg  = rhs_sign && !carryless && rs2[XLEN-1];
  assign rs1_mag  = rs1_neg ? ((~rs1) + XLEN'(1)) : rs1;
  assign rs2_mag  = rs2_neg ? ((~rs2) + XLEN'(1)) : rs2;
  assign step_idx = CW'(N_STEPS - 1) - count_q;
  assign acc_neg  = PW'(neg2x(MAX_PROD'(acc_step)));

  xc_malu_mul_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .STEP_W         (CW)
  ) u_step (
    .acc_i       (acc_q),
    .lhs_i       (lhs_q),
    .bits_i      (arg_q[BITS_PER_CYCLE-1:0]),
    .step_i      (step_idx),
    .carryless_i (cl_q),
    .acc_o       (acc_step)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    lhs_d    = lhs_q;
    arg_d    = arg_q;
    neg_d    = neg_q;
    cl_d     = cl_q;
    count_d  = count_q;
    if (flush) begin
      state_d  = ST_IDLE;
      acc_d    = '0;
      result_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            lhs_d   = rs1_mag;
            arg_d   = rs2_mag;
            neg_d   = rs1_neg ^ rs2_neg;
            cl_d    = carryless;
            acc_d   = '0;
            count_d = CW'(N_STEPS - 1);
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_d   = acc_step;
          arg_d   = arg_q >> BITS_PER_CYCLE;
          count_d = count_q - CW'(1);
          if (count_q == '0) begin
            count_d  = '0;
            result_d = neg_q ? acc_neg : acc_step;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            result_d = '0;
            state_d  = ST_IDLE;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          result_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      result_q <= '0;
      lhs_q    <= '0;
      arg_q    <= '0;
      neg_q    <= 1'b0;
      cl_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      lhs_q    <= lhs_d;
      arg_q    <= arg_d;
      neg_q    <= neg_d;
      cl_q     <= cl_d;
      count_q  <= count_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY);
  assign result    = result_q;

endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// tb/tb_xc_malu_mul_seq.sv - bench for xc_malu_mul_seq at 1 and 4 bits per cycle
module tb_xc_malu_mul_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_a, flush_a, in_valid_a, in_ready_a, ls_a, rs_a, cl_a;
  logic        out_valid_a, out_ready_a, busy_a;
  logic [31:0] rs1_a, rs2_a;
  logic [63:0] result_a;

  logic        reset_b, flush_b, in_valid_b, in_ready_b, ls_b, rs_b, cl_b;
  logic        out_valid_b, out_ready_b, busy_b;
  logic [31:0] rs1_b, rs2_b;
  logic [63:0] result_b;

  int checks = 0;
  int errors = 0;

  xc_malu_mul_seq #(.XLEN(32), .BITS_PER_CYCLE(1)) dut_a (
    .clock(clock), .reset(reset_a), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .rs1(rs1_a), .rs2(rs2_a), .lhs_sign(ls_a), .rhs_sign(rs_a), .carryless(cl_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .result(result_a), .busy(busy_a)
  );

  xc_malu_mul_seq #(.XLEN(32), .BITS_PER_CYCLE(4)) dut_b (
    .clock(clock), .reset(reset_b), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .rs1(rs1_b), .rs2(rs2_b), .lhs_sign(ls_b), .rhs_sign(rs_b), .carryless(cl_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .result(result_b), .busy(busy_b)
  );

  // Reference: integer product of sign/zero-extended operands, or GF(2) product.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic ls, input logic rs, input logic cl);
    logic [63:0] ea, eb, r;
    r = 64'd0;
    if (cl) begin
      for (int i = 0; i < 32; i++)
        if (b[i]) r = r ^ ({32'd0, a} << i);
      return r;
    end
    ea = ls ? {{32{a[31]}}, a} : {32'd0, a};
    eb = rs ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic run_a(input logic [31:0] a, input logic [31:0] b, input logic ls,
                       input logic rs, input logic cl, output logic [63:0] res, output int lat);
    logic bad_busy;
    rs1_a = a; rs2_a = b; ls_a = ls; rs_a = rs; cl_a = cl; in_valid_a = 1'b1;
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++; $display("FAIL a_accept_ready got %b want 1", in_ready_a);
    end
    step();
    in_valid_a = 1'b0;
    rs1_a = $urandom; rs2_a = $urandom; ls_a = $urandom; rs_a = $urandom; cl_a = $urandom;
    lat = 0; bad_busy = 1'b0;
    while (out_valid_a !== 1'b1 && lat < 200) begin
      if (in_ready_a !== 1'b0 || busy_a !== 1'b1 || result_a !== 64'd0) bad_busy = 1'b1;
      step();
      lat++;
    end
    checks++;
    if (bad_busy) begin
      errors++; $display("FAIL a_busy_phase in_ready/busy/result wrong while busy got 1 want 0");
    end
    res = result_a;
  endtask

  task automatic release_a;
    out_ready_a = 1'b1;
    step();
    out_ready_a = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || result_a !== 64'd0) begin
      errors++;
      $display("FAIL a_release out_valid=%b in_ready=%b result=%h want 0 1 0",
               out_valid_a, in_ready_a, result_a);
    end
  endtask

  task automatic run_b(input logic [31:0] a, input logic [31:0] b, input logic ls,
                       input logic rs, input logic cl, output logic [63:0] res, output int lat);
    rs1_b = a; rs2_b = b; ls_b = ls; rs_b = rs; cl_b = cl; in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0; rs1_b = $urandom; rs2_b = $urandom;
    lat = 0;
    while (out_valid_b !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    res = result_b;
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
  endtask

  task automatic check_op_a(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic ls, input logic rs, input logic cl, input logic [63:0] want);
    logic [63:0] res;
    int lat;
    run_a(a, b, ls, rs, cl, res, lat);
    checks++;
    if (res !== want) begin
      errors++; $display("FAIL %s result got %h want %h", name, res, want);
    end
    checks++;
    if (lat !== 32) begin
      errors++; $display("FAIL %s latency got %0d want 32", name, lat);
    end
    release_a();
  endtask

  task automatic test_reset;
    reset_a = 1'b1; flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0;
    rs1_a = '0; rs2_a = '0; ls_a = 1'b0; rs_a = 1'b0; cl_a = 1'b0;
    reset_b = 1'b1; flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    rs1_b = '0; rs2_b = '0; ls_b = 1'b0; rs_b = 1'b0; cl_b = 1'b0;
    repeat (3) step();
    checks++;
    if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0 || busy_a !== 1'b0 || result_a !== 64'd0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b busy=%b result=%h want 0 0 0 0",
               in_ready_a, out_valid_a, busy_a, result_a);
    end
    reset_a = 1'b0; reset_b = 1'b0;
    #1;
    checks++;
    if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
      errors++; $display("FAIL reset_release in_ready a=%b b=%b want 1 1", in_ready_a, in_ready_b);
    end
    step();
  endtask

  task automatic test_unsigned;
    check_op_a("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFE00000001);
  endtask

  task automatic test_signed;
    check_op_a("smul_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 64'h0000000000000001);
    check_op_a("smul_min", 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 64'h4000000000000000);
    check_op_a("mulsu", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFF00000001);
  endtask

  task automatic test_carryless;
    check_op_a("clmul_3", 32'h3, 32'h3, 1'b1, 1'b1, 1'b1, 64'h5);
    check_op_a("clmul_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 64'h5555555555555555);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic ls, rs, cl;
    for (int n = 0; n < 24; n++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: b = 32'h80000000;
        2: a = 32'h80000000;
        default: ;
      endcase
      ls = $urandom; rs = $urandom; cl = ($urandom_range(0, 3) == 0);
      check_op_a("random", a, b, ls, rs, cl, ref_mul(a, b, ls, rs, cl));
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] res, want;
    int lat;
    want = ref_mul(32'hDEADBEEF, 32'h12345679, 1'b1, 1'b0, 1'b0);
    run_a(32'hDEADBEEF, 32'h12345679, 1'b1, 1'b0, 1'b0, res, lat);
    for (int c = 0; c < 5; c++) begin
      in_valid_a = c[0]; rs1_a = $urandom; rs2_a = $urandom;
      step();
      checks++;
      if (out_valid_a !== 1'b1 || result_a !== want || in_ready_a !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold out_valid=%b in_ready=%b result=%h want 1 0 %h",
                 out_valid_a, in_ready_a, result_a, want);
      end
    end
    in_valid_a = 1'b0;
    release_a();
    check_op_a("after_bp", 32'd1234, 32'd5678, 1'b0, 1'b0, 1'b0, 64'd7006652);
  endtask

  task automatic test_flush;
    int seen;
    rs1_a = 32'h55; rs2_a = 32'h77; ls_a = 1'b0; rs_a = 1'b0; cl_a = 1'b0; in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    repeat (10) step();
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || result_a !== 64'd0) begin
      errors++;
      $display("FAIL flush_busy busy=%b out_valid=%b in_ready=%b result=%h want 0 0 1 0",
               busy_a, out_valid_a, in_ready_a, result_a);
    end
    flush_a = 1'b1; in_valid_a = 1'b1;
    step();
    flush_a = 1'b0; in_valid_a = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy_a !== 1'b0 || out_valid_a !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_no_accept activity cycles got %0d want 0", seen);
    end
    check_op_a("post_flush", 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 64'd42);
  endtask

  task automatic test_bpc4;
    logic [63:0] res;
    logic [31:0] a, b;
    logic ls, rs, cl;
    int lat;
    run_b(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, res, lat);
    checks++;
    if (res !== 64'h0B00EA4E242D2080) begin
      errors++; $display("FAIL bpc4_result got %h want 0b00ea4e242d2080", res);
    end
    checks++;
    if (lat !== 8) begin
      errors++; $display("FAIL bpc4_latency got %0d want 8", lat);
    end
    for (int n = 0; n < 8; n++) begin
      a = $urandom; b = $urandom; ls = $urandom; rs = $urandom; cl = $urandom;
      run_b(a, b, ls, rs, cl, res, lat);
      checks++;
      if (res !== ref_mul(a, b, ls, rs, cl) || lat !== 8) begin
        errors++;
        $display("FAIL bpc4_random got %h lat %0d want %h lat 8", res, lat, ref_mul(a, b, ls, rs, cl));
      end
    end
    rs1_b = 32'hFFFF; rs2_b = 32'hFFFF; in_valid_b = 1'b1;
    step();
    in_valid_b = 1'b0;
    repeat (3) step();
    reset_b = 1'b1;
    step();
    checks++;
    if (busy_b !== 1'b0 || out_valid_b !== 1'b0 || in_ready_b !== 1'b0 || result_b !== 64'd0) begin
      errors++;
      $display("FAIL bpc4_reset_busy busy=%b out_valid=%b in_ready=%b result=%h want 0 0 0 0",
               busy_b, out_valid_b, in_ready_b, result_b);
    end
    reset_b = 1'b0;
    #1;
    checks++;
    if (in_ready_b !== 1'b1) begin
      errors++; $display("FAIL bpc4_reset_release in_ready got %b want 1", in_ready_b);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_carryless();
    test_random();
    test_backpressure();
    test_flush();
    test_bpc4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
